// File: rtl/dice_roll_ctrl.sv
// dice_roll_ctrl: converts a roll request and a die selection into one
// uniformly distributed die result. Two random digits form a value 0..99,
// and that value is rejection-sampled against the largest multiple of the
// die size that is <= 100. The LFSR tap select is advanced once per roll.
// Optional build macro: DICE_HISTORY_EN keeps the previous result on last_bin.
module dice_roll_ctrl #(
    parameter int SPIN_CYCLES = 16,
    parameter int SAMPLE_GAP  = 4,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       roll,
    input  logic [2:0] die_sel,
    input  logic [3:0] rand_digit,
    output logic [2:0] mod_out,
    output logic       busy,
    output logic       spinning,
    output logic       done,
    output logic [6:0] result_bin,
    output logic [3:0] res_hund,
    output logic [3:0] res_tens,
    output logic [3:0] res_ones,
    output logic       biased,
    output logic [6:0] last_bin
);

    // One shared counter times both the spin animation and the digit gaps.
    localparam int CNT_MAX = (SPIN_CYCLES > SAMPLE_GAP) ? SPIN_CYCLES : SAMPLE_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CW-1:0] SPIN_LAST   = CW'(SPIN_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(SAMPLE_GAP - 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPIN,
        S_GET_T,
        S_GET_O,
        S_CHECK,
        S_CONV,
        S_DONE
    } state_t;

    // Number of faces for each die_sel code.
    function automatic int die_sides(input int sel);
        int sides;
        case (sel)
            0:       sides = 4;
            1:       sides = 6;
            2:       sides = 8;
            3:       sides = 10;
            4:       sides = 12;
            5:       sides = 20;
            6:       sides = 100;
            default: sides = 2;
        endcase
        return sides;
    endfunction

    // Digits above 9 from upstream are treated as 9.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Shift-and-add-3 conversion of 0..127 into three BCD digits {hund,tens,ones}.
    function automatic logic [11:0] to_bcd(input logic [6:0] bin);
        logic [18:0] sh;
        sh = {12'd0, bin};
        for (int i = 0; i < 7; i++) begin
            if (sh[10:7] >= 4'd5)  sh[10:7]  = sh[10:7]  + 4'd3;
            if (sh[14:11] >= 4'd5) sh[14:11] = sh[14:11] + 4'd3;
            if (sh[18:15] >= 4'd5) sh[18:15] = sh[18:15] + 4'd3;
            sh = sh << 1;
        end
        return sh[18:7];
    endfunction

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [RW-1:0]   retry_reg, retry_next;
    logic [2:0]      sel_reg, sel_next;
    logic [3:0]      t_reg, t_next;
    logic [3:0]      o_reg, o_next;
    logic            roll_q_reg;
    logic [6:0]      result_reg, result_next;
    logic [3:0]      hund_reg, hund_next;
    logic [3:0]      tens_reg, tens_next;
    logic [3:0]      ones_reg, ones_next;
    logic            biased_reg, biased_next;
    logic [2:0]      mod_reg, mod_next;
`ifdef DICE_HISTORY_EN
    logic [6:0]      last_reg, last_next;
`endif

    logic            roll_edge;
    logic [6:0]      pair_val;
    logic [6:0]      mod_tab [8];
    logic [6:0]      lim_tab [8];
    logic [11:0]     bcd_new;

    assign roll_edge = roll & ~roll_q_reg;
    assign pair_val  = 7'(t_reg) * 7'd10 + 7'(o_reg);

    // Per-die remainder and acceptance limit; every die uses a constant divisor.
    for (genvar gi = 0; gi < 8; gi++) begin : g_die
        localparam int SIDES = die_sides(gi);
        localparam int LIMIT = (100 / SIDES) * SIDES;
        assign mod_tab[gi] = pair_val % 7'(SIDES);
        assign lim_tab[gi] = 7'(LIMIT);
    end

    assign bcd_new = to_bcd(mod_tab[sel_reg] + 7'd1);

    // State register; reset aborts any roll in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Datapath and held-result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg    <= '0;
            retry_reg  <= '0;
            sel_reg    <= '0;
            t_reg      <= '0;
            o_reg      <= '0;
            roll_q_reg <= 1'b0;
            result_reg <= '0;
            hund_reg   <= '0;
            tens_reg   <= '0;
            ones_reg   <= '0;
            biased_reg <= 1'b0;
            mod_reg    <= '0;
`ifdef DICE_HISTORY_EN
            last_reg   <= '0;
`endif
        end else begin
            cnt_reg    <= cnt_next;
            retry_reg  <= retry_next;
            sel_reg    <= sel_next;
            t_reg      <= t_next;
            o_reg      <= o_next;
            roll_q_reg <= roll;
            result_reg <= result_next;
            hund_reg   <= hund_next;
            tens_reg   <= tens_next;
            ones_reg   <= ones_next;
            biased_reg <= biased_next;
            mod_reg    <= mod_next;
`ifdef DICE_HISTORY_EN
            last_reg   <= last_next;
`endif
        end
    end

    // Next-state and datapath updates for the roll sequence.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        retry_next  = retry_reg;
        sel_next    = sel_reg;
        t_next      = t_reg;
        o_next      = o_reg;
        result_next = result_reg;
        hund_next   = hund_reg;
        tens_next   = tens_reg;
        ones_next   = ones_reg;
        biased_next = biased_reg;
        mod_next    = mod_reg;
`ifdef DICE_HISTORY_EN
        last_next   = last_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                // Edges arriving in any other state are simply not looked at.
                if (roll_edge) begin
                    sel_next    = die_sel;
                    retry_next  = '0;
                    biased_next = 1'b0;
                    cnt_next    = '0;
                    state_next  = S_SPIN;
                end
            end
            S_SPIN: begin
                if (cnt_reg == SPIN_LAST) begin
                    cnt_next   = '0;
                    state_next = S_GET_T;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_GET_T: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next   = '0;
                    t_next     = clamp_digit(rand_digit);
                    state_next = S_GET_O;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_GET_O: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next   = '0;
                    o_next     = clamp_digit(rand_digit);
                    state_next = S_CHECK;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_CHECK: begin
                // Values at or above the limit would favour low faces; redraw.
                if (pair_val < lim_tab[sel_reg]) begin
                    state_next = S_CONV;
                end else if (retry_reg == RETRY_LIMIT) begin
                    biased_next = 1'b1;
                    state_next  = S_CONV;
                end else begin
                    retry_next = retry_reg + 1'b1;
                    state_next = S_GET_T;
                end
            end
            S_CONV: begin
`ifdef DICE_HISTORY_EN
                last_next   = result_reg;
`endif
                result_next = mod_tab[sel_reg] + 7'd1;
                hund_next   = bcd_new[11:8];
                tens_next   = bcd_new[7:4];
                ones_next   = bcd_new[3:0];
                state_next  = S_DONE;
            end
            S_DONE: begin
                mod_next   = (mod_reg == 3'd6) ? 3'd0 : mod_reg + 3'd1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_reg != S_IDLE);
    assign spinning   = (state_reg == S_SPIN);
    assign done       = (state_reg == S_DONE);
    assign mod_out    = mod_reg;
    assign result_bin = result_reg;
    assign res_hund   = hund_reg;
    // The tens/ones display follows the raw digit stream while spinning.
    assign res_tens   = spinning ? rand_digit : tens_reg;
    assign res_ones   = spinning ? rand_digit : ones_reg;
    assign biased     = biased_reg;
`ifdef DICE_HISTORY_EN
    assign last_bin   = last_reg;
`else
    assign last_bin   = '0;
`endif

endmodule
